// File: rtl/dpb_sched_pkg.sv
// Shared types and constants for the DPB slot scheduler: slot lifecycle states,
// the packet descriptor handed from writer to sender, and the length helper.
package dpb_sched_pkg;

  localparam int SLOT_NUM       = 16;
  localparam int SLOT_W         = 4;
  localparam int DESC_DEPTH     = 16;
  localparam int WORDS_PER_SLOT = 128;
  localparam int CNT128_W       = $clog2(WORDS_PER_SLOT);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } slot_state_e;

  typedef struct packed {
    logic [SLOT_W-1:0]   slot;
    logic [7:0]          udp_rank;
    logic [CNT128_W-1:0] cnt128;
    logic [5:0]          bytecnt;
    logic                last;
  } desc_t;

  // Payload bytes: 16 bytes per full word plus the trailing partial word.
  function automatic logic [15:0] jpeg_len(input logic [CNT128_W-1:0] cnt128,
                                           input logic [5:0] bytecnt);
    return ({{(16-CNT128_W){1'b0}}, cnt128} << 4) + {10'd0, bytecnt};
  endfunction

endpackage

// File: rtl/dpb_desc_fifo.sv
// Show-ahead descriptor FIFO: the head entry is presented while valid is high
// and advances on pop; empty FIFO drives an all-zero head.
module dpb_desc_fifo
  import dpb_sched_pkg::*;
#(
  parameter int DEPTH = DESC_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  desc_t din,
  input  logic  pop,
  output logic  valid,
  output desc_t dout
);

  localparam int PTR_W = $clog2(DEPTH);

  desc_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Depth covers every slot, so a push into a full FIFO means corrupted slot state.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/dpb_slot_scheduler.sv
// Arbiter for the 16 DPB slots: round-robin allocation to the writer, commit-order
// descriptor queue to the sender, and reclaim on sender release.
module dpb_slot_scheduler
  import dpb_sched_pkg::*;
(
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              i_wr_alloc_req,
  output logic              o_wr_alloc_gnt,
  output logic [SLOT_W-1:0] o_wr_slot,
  input  logic              i_wr_commit,
  input  logic [SLOT_W-1:0] i_wr_commit_slot,
  input  logic [7:0]        i_wr_udp_rank,
  input  logic [6:0]        i_wr_128cnt,
  input  logic [5:0]        i_wr_bytecnt,
  input  logic              i_wr_last,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [SLOT_W-1:0] o_rd_slot,
  output logic [14:0]       o_rd_udp_rank,
  output logic [15:0]       o_rd_jpeg_len,
  output logic              o_rd_last,
  input  logic              i_rd_release,
  input  logic [SLOT_W-1:0] i_rd_release_slot,
  output logic [SLOT_W:0]   o_free_cnt,
  output logic              o_err
);

  logic [SLOT_NUM-1:0] free_vec;
  logic [SLOT_NUM-1:0] writing_vec;
  logic [SLOT_NUM-1:0] reading_vec;
  logic [SLOT_W-1:0]   rr_ptr_reg;
  logic                gnt_reg;
  logic [SLOT_W-1:0]   wr_slot_reg;
  logic                err_reg;
  logic [SLOT_W:0]     free_cnt_reg;
  logic                found;
  logic [SLOT_W-1:0]   pick;
  logic [SLOT_W-1:0]   cand;
  logic                grant_fire;
  logic                commit_ok;
  logic                release_ok;
  logic                pop;
  logic                head_valid;
  desc_t               head;
  desc_t               push_desc;

  // First FREE slot at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      cand = rr_ptr_reg + SLOT_W'(k);
      if (!found && free_vec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign grant_fire = i_wr_alloc_req && !gnt_reg && found;
  assign commit_ok  = i_wr_commit && writing_vec[i_wr_commit_slot];
  assign release_ok = i_rd_release && reading_vec[i_rd_release_slot];
  assign pop        = head_valid && i_rd_ready;

  assign push_desc = '{slot:     i_wr_commit_slot,
                       udp_rank: i_wr_udp_rank,
                       cnt128:   i_wr_128cnt,
                       bytecnt:  i_wr_bytecnt,
                       last:     i_wr_last};

  // Each event only acts on a slot in one specific state, so per slot they never collide.
  genvar gi;
  generate
    for (gi = 0; gi < SLOT_NUM; gi++) begin : g_slot
      slot_state_e state_reg;

      always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
          state_reg <= FREE;
        else if (grant_fire && pick == SLOT_W'(gi))
          state_reg <= WRITING;
        else if (commit_ok && i_wr_commit_slot == SLOT_W'(gi))
          state_reg <= READY;
        else if (pop && head.slot == SLOT_W'(gi))
          state_reg <= READING;
        else if (release_ok && i_rd_release_slot == SLOT_W'(gi))
          state_reg <= FREE;
      end

      assign free_vec[gi]    = (state_reg == FREE);
      assign writing_vec[gi] = (state_reg == WRITING);
      assign reading_vec[gi] = (state_reg == READING);
    end
  endgenerate

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_reg      <= 1'b0;
      wr_slot_reg  <= '0;
      rr_ptr_reg   <= '0;
      err_reg      <= 1'b0;
      free_cnt_reg <= (SLOT_W+1)'(SLOT_NUM);
    end else begin
      gnt_reg <= grant_fire;
      if (grant_fire) begin
        wr_slot_reg <= pick;
        rr_ptr_reg  <= pick + 1'b1;
      end
      err_reg      <= (i_wr_commit && !commit_ok) || (i_rd_release && !release_ok);
      free_cnt_reg <= free_cnt_reg + {{SLOT_W{1'b0}}, release_ok}
                                   - {{SLOT_W{1'b0}}, grant_fire};
    end
  end

  dpb_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk   (i_pclk),
    .rst_n (i_rst_n),
    .push  (commit_ok),
    .din   (push_desc),
    .pop   (pop),
    .valid (head_valid),
    .dout  (head)
  );

  assign o_wr_alloc_gnt = gnt_reg;
  assign o_wr_slot      = wr_slot_reg;
  assign o_err          = err_reg;
  assign o_free_cnt     = free_cnt_reg;
  assign o_rd_valid     = head_valid;
  assign o_rd_slot      = head.slot;
  assign o_rd_udp_rank  = {7'd0, head.udp_rank};
  assign o_rd_jpeg_len  = jpeg_len(head.cnt128, head.bytecnt);
  assign o_rd_last      = head.last;

endmodule

// File: tb/tb_dpb_slot_scheduler.sv
// Bench for dpb_slot_scheduler: directed scenarios with literal expectations, then
// random writer/sender traffic checked every cycle against a slot-table model.
module tb_dpb_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [3:0]  wr_slot;
  logic        commit;
  logic [3:0]  commit_slot;
  logic [7:0]  udp_rank;
  logic [6:0]  cnt128;
  logic [5:0]  bytecnt;
  logic        wr_last;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  rd_slot;
  logic [14:0] rd_rank;
  logic [15:0] rd_len;
  logic        rd_last;
  logic        rel;
  logic [3:0]  rel_slot;
  logic [4:0]  free_cnt;
  logic        err;

  always #5 clk = ~clk;

  dpb_slot_scheduler dut (
    .i_pclk            (clk),
    .i_rst_n           (rst_n),
    .i_wr_alloc_req    (req),
    .o_wr_alloc_gnt    (gnt),
    .o_wr_slot         (wr_slot),
    .i_wr_commit       (commit),
    .i_wr_commit_slot  (commit_slot),
    .i_wr_udp_rank     (udp_rank),
    .i_wr_128cnt       (cnt128),
    .i_wr_bytecnt      (bytecnt),
    .i_wr_last         (wr_last),
    .o_rd_valid        (rd_valid),
    .i_rd_ready        (rd_ready),
    .o_rd_slot         (rd_slot),
    .o_rd_udp_rank     (rd_rank),
    .o_rd_jpeg_len     (rd_len),
    .o_rd_last         (rd_last),
    .i_rd_release      (rel),
    .i_rd_release_slot (rel_slot),
    .o_free_cnt        (free_cnt),
    .o_err             (err)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: 0 = FREE, 1 = WRITING, 2 = READY, 3 = READING
  typedef struct {
    int slot;
    int rank;
    int cnt;
    int bytes;
    int last;
  } mdesc_t;

  int     m_state [16];
  mdesc_t mq [$];
  int     m_rr;
  int     m_gnt;
  int     m_wr_slot;
  int     m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int s = 0; s < 16; s++) if (m_state[s] == 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) m_state[s] = 0;
    mq.delete();
    m_rr = 0; m_gnt = 0; m_wr_slot = 0; m_err = 0;
  endtask

  // Apply one clock edge worth of events, using the inputs the DUT just sampled.
  task automatic model_step();
    int     pick;
    bit     cok;
    bit     rok;
    bit     popped;
    mdesc_t d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pick = -1;
    if (req && m_gnt == 0) begin
      for (int k = 0; k < 16; k++) begin
        if (pick < 0 && m_state[(m_rr + k) % 16] == 0) pick = (m_rr + k) % 16;
      end
    end
    cok    = commit && m_state[commit_slot] == 1;
    rok    = rel && m_state[rel_slot] == 3;
    popped = (mq.size() > 0) && rd_ready;
    if (popped) begin
      d = mq.pop_front();
      m_state[d.slot] = 3;
    end
    if (cok) begin
      d.slot = commit_slot; d.rank = udp_rank; d.cnt = cnt128;
      d.bytes = bytecnt; d.last = wr_last;
      mq.push_back(d);
      m_state[commit_slot] = 2;
    end
    if (rok) m_state[rel_slot] = 0;
    m_gnt = (pick >= 0) ? 1 : 0;
    if (pick >= 0) begin
      m_state[pick] = 1;
      m_rr = (pick + 1) % 16;
      m_wr_slot = pick;
    end
    m_err = ((commit && !cok) || (rel && !rok)) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt", gnt, m_gnt);
      check("wr_slot", wr_slot, m_wr_slot);
      check("err", err, m_err);
      check("free_cnt", free_cnt, m_free());
      check("rd_valid", rd_valid, (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0 && rd_valid) begin
        check("rd_slot", rd_slot, mq[0].slot);
        check("rd_rank", rd_rank, mq[0].rank);
        check("rd_len", rd_len, mq[0].cnt * 16 + mq[0].bytes);
        check("rd_last", rd_last, mq[0].last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic wait_gnt(output int slot);
    slot = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt) begin
        slot = wr_slot;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL gnt_timeout: got no grant within 8 cycles at %0t", $time);
  endtask

  task automatic commit_pulse(input int s, input int r, input int c, input int b, input int l);
    commit = 1'b1; commit_slot = 4'(s); udp_rank = 8'(r);
    cnt128 = 7'(c); bytecnt = 6'(b); wr_last = l[0];
    tick();
    commit = 1'b0;
  endtask

  task automatic release_pulse(input int s);
    rel = 1'b1; rel_slot = 4'(s);
    tick();
    rel = 1'b0;
  endtask

  task automatic accept();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int s;
    int wl [$];
    int rl [$];
    rst_n = 1'b0; req = 1'b0; commit = 1'b0; commit_slot = '0;
    udp_rank = '0; cnt128 = '0; bytecnt = '0; wr_last = 1'b0;
    rd_ready = 1'b0; rel = 1'b0; rel_slot = '0;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_free_cnt", free_cnt, 16);
    check("rst_valid", rd_valid, 0);
    check("rst_gnt", gnt, 0);
    check("rst_wr_slot", wr_slot, 0);
    check("rst_rd_len", rd_len, 0);

    // Three grants from reset: 0, 1, 2
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(s);
      check("first_grants", s, k);
    end
    req = 1'b0;
    check("free_after_3", free_cnt, 13);
    check("model_free_after_3", m_free(), 13);

    commit_pulse(1, 5, 10, 3, 1);
    check("c1_valid", rd_valid, 1);
    check("c1_slot", rd_slot, 1);
    check("c1_len", rd_len, 163);
    check("c1_last", rd_last, 1);
    check("c1_rank", rd_rank, 5);
    accept();
    release_pulse(1);

    // Commit to a FREE slot: one error pulse, nothing else moves
    commit_pulse(4, 0, 0, 0, 0);
    check("bad_commit_err", err, 1);
    check("bad_commit_free", free_cnt, 14);
    check("bad_commit_valid", rd_valid, 0);
    tick();
    check("bad_commit_err_clr", err, 0);

    commit_pulse(2, 0, 1, 0, 0);
    check("c2_len", rd_len, 16);
    release_pulse(2);
    check("bad_release_err", err, 1);
    check("bad_release_head", rd_slot, 2);
    check("bad_release_free", free_cnt, 14);
    accept();
    release_pulse(2);
    commit_pulse(0, 9, 127, 63, 0);
    check("c0_len_max", rd_len, 2095);
    accept();
    release_pulse(0);
    check("all_free", free_cnt, 16);

    // Exhaust every slot; rr pointer is 3 here
    req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_gnt(s);
      check("fill_grant", s, (3 + k) % 16);
    end
    check("full_free", free_cnt, 0);
    repeat (3) begin
      tick();
      check("no_free_gnt", gnt, 0);
      check("no_free_err", err, 0);
    end
    commit_pulse(7, 1, 2, 3, 0);
    accept();
    release_pulse(7);
    check("no_bypass_gnt", gnt, 0);
    tick();
    check("regrant_gnt", gnt, 1);
    check("regrant_slot", wr_slot, 7);
    req = 1'b0;

    // Commit order 3, 0, 5 must reach the sender in that order
    commit_pulse(3, 3, 1, 1, 0);
    commit_pulse(0, 0, 1, 1, 0);
    commit_pulse(5, 5, 1, 1, 1);
    rd_ready = 1'b1;
    check("order_0", rd_slot, 3);
    tick();
    check("order_1", rd_slot, 0);
    tick();
    check("order_2", rd_slot, 5);
    tick();
    check("order_empty", rd_valid, 0);
    rd_ready = 1'b0;

    // Commit and pop in the same cycle
    commit_pulse(8, 8, 4, 0, 0);
    rd_ready = 1'b1;
    commit_pulse(9, 9, 4, 2, 1);
    rd_ready = 1'b0;
    check("cp_valid", rd_valid, 1);
    check("cp_slot", rd_slot, 9);
    check("cp_len", rd_len, 66);
    check("model_queue_len", mq.size(), 1);

    // Reset with slots 3, 0, 5, 8 READING
    rst_n = 1'b0;
    model_reset();
    #2;
    check("mid_rst_free", free_cnt, 16);
    check("mid_rst_valid", rd_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    req = 1'b1;
    wait_gnt(s);
    check("post_rst_grant", s, 0);
    req = 1'b0;

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc == 1500) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      if (m_gnt != 0) req = 1'b0;
      else if (!req) req = ($urandom_range(0, 2) == 0);
      wl.delete();
      rl.delete();
      for (int k = 0; k < 16; k++) begin
        if (m_state[k] == 1) wl.push_back(k);
        if (m_state[k] == 3) rl.push_back(k);
      end
      commit = 1'b0;
      if (wl.size() > 0 && $urandom_range(0, 2) == 0) begin
        commit = 1'b1;
        commit_slot = 4'(wl[$urandom_range(0, wl.size() - 1)]);
      end else if ($urandom_range(0, 29) == 0) begin
        commit = 1'b1;
        commit_slot = 4'($urandom_range(0, 15));
      end
      udp_rank = 8'($urandom_range(0, 255));
      cnt128   = 7'($urandom_range(0, 127));
      bytecnt  = 6'($urandom_range(0, 63));
      wr_last  = 1'($urandom_range(0, 1));
      rel = 1'b0;
      if (rl.size() > 0 && $urandom_range(0, 2) == 0) begin
        rel = 1'b1;
        rel_slot = 4'(rl[$urandom_range(0, rl.size() - 1)]);
      end else if ($urandom_range(0, 29) == 0) begin
        rel = 1'b1;
        rel_slot = 4'($urandom_range(0, 15));
      end
      rd_ready = 1'($urandom_range(0, 1));
    end
    commit = 1'b0; rel = 1'b0; req = 1'b0; rd_ready = 1'b0;
    tick();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpb_slot_scheduler.md
Name: dpb_slot_scheduler

Overview:
- Owns the 16 slots (buffer ranks) of the 2048x128 packet DPB shared between the DDR3 read-back writer and the udp128 packet sender.
- Hands free slots to the writer and queues committed slots in commit order for the sender.
- Reclaims each slot when the sender reports its UDP frame done.
- Replaces ad-hoc rank bookkeeping in the DDR3 master and DPB read controller with one arbiter.

Parameters:
SLOT_NUM, 16, number of DPB slots (one slot = 128 x 128-bit words)
SLOT_W, 4, slot index width, equals clog2(SLOT_NUM)
DESC_DEPTH, 16, descriptor FIFO depth, must be >= SLOT_NUM

Ports:
i_pclk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_wr_alloc_req  in  1  writer requests a free slot; level, held until grant
o_wr_alloc_gnt  out  1  one-cycle grant pulse
o_wr_slot  out  SLOT_W  granted slot, valid with grant, held until next grant
i_wr_commit  in  1  one-cycle pulse: slot filled
i_wr_commit_slot  in  SLOT_W  slot being committed
i_wr_udp_rank  in  8  UDP packet rank within frame
i_wr_128cnt  in  7  full 128-bit words in slot
i_wr_bytecnt  in  6  trailing byte count
i_wr_last  in  1  last packet of MJPEG frame
o_rd_valid  out  1  descriptor available at FIFO head
i_rd_ready  in  1  sender accepts head descriptor
o_rd_slot  out  SLOT_W  head slot
o_rd_udp_rank  out  15  zero-extended UDP rank
o_rd_jpeg_len  out  16  payload length in bytes
o_rd_last  out  1  head is frame-last packet
i_rd_release  in  1  one-cycle pulse: sender finished slot
i_rd_release_slot  in  SLOT_W  slot being released
o_free_cnt  out  SLOT_W+1  number of FREE slots
o_err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset values:
  - all slots FREE; FIFO empty; o_free_cnt = SLOT_NUM.
  - o_wr_alloc_gnt, o_rd_valid, o_err = 0; o_wr_slot = 0.
  - round-robin pointer = 0; all descriptor outputs = 0.
- Reset mid-operation discards every in-flight slot; no release is required afterwards.
- Per-slot state: FREE -> WRITING (grant) -> READY (commit) -> READING (rd accept) -> FREE (release).
- Allocation:
  - when i_wr_alloc_req = 1, o_wr_alloc_gnt = 0 and a FREE slot exists, the block picks the first FREE slot at or after the rr pointer (wrapping 15 -> 0).
  - o_wr_alloc_gnt and o_wr_slot are registered one cycle later; the slot goes to WRITING and the rr pointer = slot + 1 mod SLOT_NUM.
  - no free slot: request waits; no grant and no error.
  - minimum two cycles between grants, since the writer drops req on grant.
- Commit:
  - slot must be WRITING, otherwise the commit is ignored and o_err pulses.
  - valid commit pushes descriptor {slot, udp_rank, 128cnt, bytecnt, last}; slot goes to READY.
  - o_rd_jpeg_len = (128cnt << 4) + bytecnt, computed in 16 bits (max 2095).
- Read port:
  - show-ahead; o_rd_valid = FIFO not empty; outputs are valid while o_rd_valid = 1.
  - o_rd_valid && i_rd_ready pops the descriptor; slot goes to READING; the next head appears the following cycle.
- Release:
  - slot must be READING, otherwise it is ignored and o_err pulses.
  - valid release sets the slot FREE, visible to allocation the next cycle (no same-cycle bypass).
- Simultaneous events: commit + pop in one cycle both apply; FIFO count unchanged. Allocate + release in one cycle are both applied.
- FIFO cannot overflow because DESC_DEPTH >= SLOT_NUM. A push into a full FIFO is an assertion failure in simulation.
- o_free_cnt is updated every cycle: +1 per release, -1 per grant.

Decomposition:
- Package dpb_sched_pkg:
  - slot_state_e enum {FREE, WRITING, READY, READING};
  - desc_t struct {slot, udp_rank, cnt128, bytecnt, last};
  - constants SLOT_NUM, SLOT_W, WORDS_PER_SLOT = 128.
- Sub-module dpb_desc_fifo: synchronous show-ahead FIFO of desc_t.
- Allocation priority encoder stays inline.

Test Plan:
- Reset, req held 3 grants: grants slots 0, 1, 2; o_free_cnt 16 -> 13.
- Commit slot 1 (rank 5, 128cnt = 10, bytecnt = 3, last = 1): o_rd_valid next cycle, o_rd_slot = 1, o_rd_jpeg_len = 163, o_rd_last = 1.
- Allocate all 16, then request: no grant. Commit, accept, release slot 7: grant of slot 7 one cycle later.
- Commit slot 4 while FREE, or release slot 2 while READY: single o_err pulse, state unchanged, o_free_cnt unchanged.
- Commit slots 3, 0, 5 in that order: sender sees 3, 0, 5. Commit + accept in the same cycle keeps order and does not lose the descriptor.
- Assert i_rst_n low with 4 slots READING: after reset o_free_cnt = 16, o_rd_valid = 0, next grant = slot 0.
